// File: rtl/irq_sched.sv
// irq_sched: three-line prioritized interrupt scheduler sitting between the
// board IRQ pins and the CPU exception unit. Synchronizes and edge-detects
// each line, holds pending bits, applies a mask, requests the CPU with a
// frozen handshake and tracks in-service levels (irw) for nested ISRs.
// Line 2 has the highest priority.
//
// Optional feature: define IRQ_SCHED_NESTING_EN to allow a strictly
// higher-priority line to request while another ISR is in service.
// Without it, nothing requests while any irw bit is set.
module irq_sched #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(32'h0000_0100)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       irq,
    input  logic             mask_we,
    input  logic [2:0]       mask_wdata,
    output logic             int_req,
    input  logic             int_ack,
    output logic [1:0]       int_id,
    output logic [WIDTH-1:0] int_vec,
    input  logic             eret,
    output logic [2:0]       irw,
    output logic [2:0]       mask
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] int_id_q, int_id_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] irw_q, irw_d;
    logic [2:0] mask_q, mask_d;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] sync3_q, sync3_d;

    logic [2:0] irq_edge;
    logic [2:0] eligible;
    logic       ack_take;
    logic [2:0] ack_onehot;

    // One-hot of the highest set bit (zero for an all-zero input).
    function automatic logic [2:0] top_onehot(input logic [2:0] v);
        logic [2:0] r;
        r = '0;
        if (v[2])
            r = 3'b100;
        else if (v[1])
            r = 3'b010;
        else if (v[0])
            r = 3'b001;
        return r;
    endfunction

    // Index of the highest set bit (0 for an all-zero input).
    function automatic logic [1:0] top_index(input logic [2:0] v);
        logic [1:0] r;
        r = 2'd0;
        if (v[2])
            r = 2'd2;
        else if (v[1])
            r = 2'd1;
        return r;
    endfunction

    // Two-flop synchronizer per line plus a third stage for edge detection.
    always_comb begin
        sync1_d  = irq;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        irq_edge = sync2_q & ~sync3_q;
    end

    // Lines allowed to request: unmasked pendings above the current service level.
    always_comb begin
        eligible = pending_q & ~mask_q;
`ifdef IRQ_SCHED_NESTING_EN
        if (irw_q[2])
            eligible = '0;
        else if (irw_q[1])
            eligible = eligible & 3'b100;
        else if (irw_q[0])
            eligible = eligible & 3'b110;
`else
        if (irw_q != '0)
            eligible = '0;
`endif
    end

    // Request handshake FSM: latch the winning line in IDLE, hold it until ack.
    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    state_d  = REQ;
                    int_id_d = top_index(eligible);
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d  = IDLE;
                    ack_take = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending, in-service and mask updates; eret works on the pre-ack irw,
    // and an edge arriving with the ack on the same line keeps it pending.
    always_comb begin
        ack_onehot = ack_take ? (3'b001 << int_id_q) : 3'b000;
        pending_d  = (pending_q & ~ack_onehot) | irq_edge;
        irw_d      = irw_q;
        if (eret)
            irw_d = irw_q & ~top_onehot(irw_q);
        irw_d  = irw_d | ack_onehot;
        mask_d = mask_we ? mask_wdata : mask_q;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            int_id_q  <= '0;
            pending_q <= '0;
            irw_q     <= '0;
            mask_q    <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
        end else begin
            state_q   <= state_d;
            int_id_q  <= int_id_d;
            pending_q <= pending_d;
            irw_q     <= irw_d;
            mask_q    <= mask_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        int_req = (state_q == REQ);
        int_id  = int_id_q;
        int_vec = VEC_BASE + (WIDTH'(int_id_q) * VEC_STRIDE);
        irw     = irw_q;
        mask    = mask_q;
    end

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched. Follows IRQ_SCHED_NESTING_EN like the design.
module tb_irq_sched;

    localparam logic [31:0] VB = 32'h0000_3000;
    localparam logic [31:0] VS = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  irq = '0;
    logic        mask_we = 1'b0;
    logic [2:0]  mask_wdata = '0;
    logic        int_req;
    logic        int_ack = 1'b0;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic        eret = 1'b0;
    logic [2:0]  irw;
    logic [2:0]  mask;

    int checks = 0;
    int errors = 0;

    irq_sched #(
        .WIDTH(32),
        .VEC_BASE(32'h0000_3000),
        .VEC_STRIDE(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq(irq),
        .mask_we(mask_we),
        .mask_wdata(mask_wdata),
        .int_req(int_req),
        .int_ack(int_ack),
        .int_id(int_id),
        .int_vec(int_vec),
        .eret(eret),
        .irw(irw),
        .mask(mask)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [2:0] hist[$] = '{3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] m_pend = '0;
    logic [2:0] m_irw = '0;
    logic [2:0] m_mask = '0;
    bit         m_req = 0;
    int         m_id = 0;

    function automatic bit line_allowed(int line, int top_irw);
`ifdef IRQ_SCHED_NESTING_EN
        return line > top_irw;
`else
        return top_irw < 0;
`endif
    endfunction

    task automatic model_step();
        int top_irw;
        int best;
        logic [2:0] edge_v;
        logic [2:0] new_pend;
        logic [2:0] new_irw;
        top_irw = -1;
        for (int i = 0; i < 3; i++) if (m_irw[i]) top_irw = i;
        best = -1;
        for (int i = 0; i < 3; i++)
            if (m_pend[i] && !m_mask[i] && line_allowed(i, top_irw)) best = i;
        // an irq rise is seen in pending two samples after it is first sampled
        hist.push_front(irq);
        edge_v = hist[2] & ~hist[3];
        void'(hist.pop_back());
        new_pend = m_pend;
        new_irw  = m_irw;
        if (eret && top_irw >= 0) new_irw[top_irw] = 1'b0;
        if (m_req) begin
            if (int_ack) begin
                new_pend[m_id] = 1'b0;
                new_irw[m_id]  = 1'b1;
                m_req = 0;
            end
        end else if (best >= 0) begin
            m_req = 1;
            m_id  = best;
        end
        m_pend = new_pend | edge_v;
        m_irw  = new_irw;
        if (mask_we) m_mask = mask_wdata;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist   = '{3'b000, 3'b000, 3'b000, 3'b000};
            m_pend = '0;
            m_irw  = '0;
            m_mask = '0;
            m_req  = 0;
            m_id   = 0;
        end else begin
            model_step();
        end
    end

    function automatic logic [40:0] mdl_out();
        logic [31:0] v;
        v = VB + 32'(m_id) * VS;
        return {m_req, 2'(m_id), v, m_irw, m_mask};
    endfunction

    function automatic logic [40:0] dut_out();
        return {int_req, int_id, int_vec, irw, mask};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            irq = 3'(i % 2 == 0 ? 7 : 0);
            tick();
            checks++;
            if (dut_out() !== {1'b0, 2'd0, VB, 3'b000, 3'b000}) begin
                errors++;
                $display("FAIL reset_hold: got %h expected %h", dut_out(), {1'b0, 2'd0, VB, 3'b000, 3'b000});
            end
        end
        irq = '0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (int_req !== 1'b0 || dut_out() !== mdl_out()) begin
                errors++;
                $display("FAIL reset_release: got %h expected %h", dut_out(), mdl_out());
            end
        end
    endtask

    task automatic test_single();
        int d;
        // ack with nothing requested must be ignored
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if (irw !== 3'b000 || int_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: got irw=%b req=%b expected irw=000 req=0", irw, int_req);
        end
        irq = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (int_req !== 1'b0 || dut_out() !== mdl_out()) begin
                errors++;
                $display("FAIL single_latency: got %h expected %h", dut_out(), mdl_out());
            end
        end
        tick();
        checks++;
        if ({int_req, int_id, int_vec} !== {1'b1, 2'd0, 32'h0000_3000}) begin
            errors++;
            $display("FAIL single_req: got req=%b id=%0d vec=%h expected 1 0 00003000", int_req, int_id, int_vec);
        end
        irq = 3'b000;
        d = $urandom_range(0, 4);
        for (int i = 0; i < d; i++) begin
            tick();
            checks++;
            if (dut_out() !== mdl_out() || int_req !== 1'b1) begin
                errors++;
                $display("FAIL single_hold: got %h expected %h", dut_out(), mdl_out());
            end
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if ({int_req, irw} !== {1'b0, 3'b001}) begin
            errors++;
            $display("FAIL single_ack: got req=%b irw=%b expected 0 001", int_req, irw);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++;
        if (irw !== 3'b000 || dut_out() !== mdl_out()) begin
            errors++;
            $display("FAIL single_eret: got irw=%b expected 000", irw);
        end
        tick();
    endtask

    task automatic test_priority();
        irq = 3'b101;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({int_req, int_id, int_vec} !== {1'b1, 2'd2, 32'h0000_3200}) begin
            errors++;
            $display("FAIL prio_req: got req=%b id=%0d vec=%h expected 1 2 00003200", int_req, int_id, int_vec);
        end
        irq = 3'b000;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if ({int_req, irw} !== {1'b0, 3'b100}) begin
            errors++;
            $display("FAIL prio_ack: got req=%b irw=%b expected 0 100", int_req, irw);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (int_req !== 1'b0 || dut_out() !== mdl_out()) begin
                errors++;
                $display("FAIL prio_no_low: got %h expected %h", dut_out(), mdl_out());
            end
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        checks++;
        if ({int_req, int_id, irw} !== {1'b1, 2'd0, 3'b000}) begin
            errors++;
            $display("FAIL prio_low_after_eret: got req=%b id=%0d irw=%b expected 1 0 000", int_req, int_id, irw);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_nesting();
        irq = 3'b001;
        for (int i = 0; i < 4; i++) tick();
        irq = 3'b000;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if (irw !== 3'b001) begin
            errors++;
            $display("FAIL nest_first_ack: got irw=%b expected 001", irw);
        end
        irq = 3'b010;
`ifdef IRQ_SCHED_NESTING_EN
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({int_req, int_id} !== {1'b1, 2'd1}) begin
            errors++;
            $display("FAIL nest_preempt: got req=%b id=%0d expected 1 1", int_req, int_id);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if (irw !== 3'b011) begin
            errors++;
            $display("FAIL nest_irw2: got irw=%b expected 011", irw);
        end
        eret = 1'b1;
        tick();
        checks++;
        if (irw !== 3'b001) begin
            errors++;
            $display("FAIL nest_eret1: got irw=%b expected 001", irw);
        end
        tick();
        eret = 1'b0;
        checks++;
        if (irw !== 3'b000) begin
            errors++;
            $display("FAIL nest_eret2: got irw=%b expected 000", irw);
        end
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (int_req !== 1'b0 || dut_out() !== mdl_out()) begin
                errors++;
                $display("FAIL nonest_blocked: got %h expected %h", dut_out(), mdl_out());
            end
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        checks++;
        if ({int_req, int_id, irw} !== {1'b1, 2'd1, 3'b000}) begin
            errors++;
            $display("FAIL nonest_after_eret: got req=%b id=%0d irw=%b expected 1 1 000", int_req, int_id, irw);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0;
`endif
        irq = 3'b000;
        tick();
    endtask

    task automatic test_mask();
        bit seen;
        mask_we = 1'b1;
        mask_wdata = 3'b010;
        tick();
        mask_we = 1'b0;
        checks++;
        if (mask !== 3'b010) begin
            errors++;
            $display("FAIL mask_write: got %b expected 010", mask);
        end
        irq = 3'b010;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (int_req !== 1'b0 || dut_out() !== mdl_out()) begin
                errors++;
                $display("FAIL mask_blocked: got %h expected %h", dut_out(), mdl_out());
            end
        end
        irq = 3'b000;
        mask_we = 1'b1;
        mask_wdata = 3'b000;
        tick();
        mask_we = 1'b0;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            seen = int_req;
        end
        checks++;
        if ({seen, int_id, mask} !== {1'b1, 2'd1, 3'b000}) begin
            errors++;
            $display("FAIL mask_release: got req=%b id=%0d mask=%b expected 1 1 000", seen, int_id, mask);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_eret_ack();
        irq = 3'b001;
        for (int i = 0; i < 4; i++) tick();
        irq = 3'b000;
`ifdef IRQ_SCHED_NESTING_EN
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq = 3'b100;
        for (int i = 0; i < 4; i++) tick();
        irq = 3'b000;
        checks++;
        if ({int_req, int_id, irw} !== {1'b1, 2'd2, 3'b001}) begin
            errors++;
            $display("FAIL ea_setup: got req=%b id=%0d irw=%b expected 1 2 001", int_req, int_id, irw);
        end
        int_ack = 1'b1;
        eret = 1'b1;
        tick();
        int_ack = 1'b0;
        eret = 1'b0;
        checks++;
        if ({int_req, irw} !== {1'b0, 3'b100}) begin
            errors++;
            $display("FAIL ea_same_cycle: got req=%b irw=%b expected 0 100", int_req, irw);
        end
`else
        int_ack = 1'b1;
        eret = 1'b1;
        tick();
        int_ack = 1'b0;
        eret = 1'b0;
        checks++;
        if ({int_req, irw} !== {1'b0, 3'b001}) begin
            errors++;
            $display("FAIL ea_same_cycle: got req=%b irw=%b expected 0 001", int_req, irw);
        end
`endif
        eret = 1'b1;
        tick();
        eret = 1'b0;
        checks++;
        if (irw !== 3'b000) begin
            errors++;
            $display("FAIL ea_final_eret: got irw=%b expected 000", irw);
        end
        tick();
    endtask

    task automatic test_edge_ack_same_line();
        irq = 3'b001;
        for (int i = 0; i < 4; i++) tick();
        irq = 3'b000;
        tick();
        irq = 3'b001;
        tick();
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq = 3'b000;
        checks++;
        if ({int_req, irw} !== {1'b0, 3'b001} || dut_out() !== mdl_out()) begin
            errors++;
            $display("FAIL edge_ack_ack: got %h expected %h", dut_out(), mdl_out());
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        checks++;
        if ({int_req, int_id} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL edge_ack_kept: got req=%b id=%0d expected 1 0", int_req, int_id);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_req();
        irq = 3'b100;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (int_req !== 1'b1) begin
            errors++;
            $display("FAIL midreq_setup: got req=%b expected 1", int_req);
        end
        rst = 1'b0;
        irq = 3'b000;
        #1;
        checks++;
        if (dut_out() !== {1'b0, 2'd0, VB, 3'b000, 3'b000}) begin
            errors++;
            $display("FAIL midreq_async: got %h expected %h", dut_out(), {1'b0, 2'd0, VB, 3'b000, 3'b000});
        end
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (int_req !== 1'b0 || dut_out() !== mdl_out()) begin
                errors++;
                $display("FAIL midreq_after: got %h expected %h", dut_out(), mdl_out());
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 3) == 0) irq[b] = ~irq[b];
            int_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            eret = ($urandom_range(0, 9) == 0);
            mask_we = ($urandom_range(0, 19) == 0);
            mask_wdata = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (dut_out() !== mdl_out()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, dut_out(), mdl_out());
            end
        end
        int_ack = 1'b0;
        eret = 1'b0;
        mask_we = 1'b0;
        irq = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_mask();
        test_eret_ack();
        test_edge_ack_same_line();
        test_reset_mid_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
